// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces presses and
// shifts each accepted hex digit into a 16-bit entry register.
// Optional feature: define KEYPAD_REPEAT_EN to auto-repeat a held key every
// REPEAT_TICKS scan ticks.
module keypad_entry #(
  parameter int unsigned DIV_BITS     = 15,
  parameter int unsigned DEB_TICKS    = 4,
  parameter int unsigned REPEAT_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] num,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held
);

  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_TICKS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // A debounce count of zero would never accept anything.
  if (DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_entry: DEB_TICKS and REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_BITS-1:0] pre_q;
  logic [3:0]        row_s1_q, row_s2_q;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic [15:0]       num_q, num_d;
  logic [3:0]        key_q, key_d;
  logic              key_valid_q;
  logic              tick;
  logic              any_low;
  logic [1:0]        row_idx;
  logic              accept;
  logic [3:0]        acc_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_TICKS);
  logic [RepW-1:0]   rep_q, rep_d;
`endif

  // Free-running scan prescaler; tick on the all-ones cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign tick = &pre_q;

  // Two-flop synchronizer for the asynchronous row inputs; idle is all high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  // Lowest-index low row wins when several rows are low.
  always_comb begin
    any_low = ~&row_s2_q;
    row_idx = 2'd0;
    if (!row_s2_q[0]) begin
      row_idx = 2'd0;
    end else if (!row_s2_q[1]) begin
      row_idx = 2'd1;
    end else if (!row_s2_q[2]) begin
      row_idx = 2'd2;
    end else if (!row_s2_q[3]) begin
      row_idx = 2'd3;
    end
  end

  // Scan/debounce FSM next-state; every decision is gated by tick.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    accept    = 1'b0;
    acc_code  = code_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif
    unique case (state_q)
      StScan: begin
        if (tick) begin
          if (any_low) begin
            code_d   = {row_idx, col_idx_q};
            acc_code = {row_idx, col_idx_q};
            cnt_d    = CntOne;
            if (DEB_TICKS == 1) begin
              accept  = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StDebounce;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (tick) begin
          if (any_low && (row_idx == code_q[3:2])) begin
            if ((cnt_q + CntOne) == DebMax) begin
              accept  = 1'b1;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            // Bounce or different key: drop it and keep scanning.
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      StHeld: begin
        if (tick) begin
          if (!any_low) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (DEB_TICKS == 1) begin
              state_d   = StScan;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if ((rep_q + 1'b1) == RepMax) begin
              accept = 1'b1;
              rep_d  = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
      end
      StRelease: begin
        if (tick) begin
          if (!any_low) begin
            if ((cnt_q + CntOne) == DebMax) begin
              state_d   = StScan;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            cnt_d = CntOne;
          end
        end
      end
      default: begin
        state_d = StScan;
      end
    endcase
  end

  // Entry register and last-key capture on accept.
  always_comb begin
    num_d = num_q;
    key_d = key_q;
    if (accept) begin
      num_d = {num_q[11:0], acc_code};
      key_d = acc_code;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StScan;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      code_q      <= 4'h0;
      num_q       <= 16'h0000;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      num_q       <= num_d;
      key_q       <= key_d;
      key_valid_q <= accept;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat counter: ticks spent in HELD since the last accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign col       = ~(4'b0001 << col_idx_q);
  assign num       = num_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == StHeld) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a behavioural keypad matrix drives the rows, a
// scoreboard queue holds expected key codes, a monitor checks every pulse.
module tb_keypad_entry;

  localparam int unsigned DivBits     = 2;
  localparam int unsigned DebTicks    = 3;
  localparam int unsigned RepeatTicks = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] num;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;

  logic [15:0]        pressed = 16'h0000;
  logic [3:0]         exp_q[$];
  logic [15:0]        model_num = 16'h0000;
  logic [DivBits-1:0] tb_pre;
  int                 errors = 0;
  int                 checks = 0;
  int                 pulses = 0;

  always #5 clk = ~clk;

  keypad_entry #(
    .DIV_BITS    (DivBits),
    .DEB_TICKS   (DebTicks),
    .REPEAT_TICKS(RepeatTicks)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .num      (num),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Matrix: key r*4+c pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Reference scan-tick phase: free-running counter cleared by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_pre <= '0;
    else     tb_pre <= tb_pre + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected code on every pulse and compare key and num.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got key %0h num %0h, expected no pulse", key, num);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        model_num = {model_num[11:0], e};
        check("pulse_key", key, e);
        check("pulse_num", num, model_num);
      end
    end
  end

  // Returns 1 time unit after the next scan-tick clock edge.
  task automatic wait_tick();
    @(negedge clk);
    while (tb_pre != 2'd3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: got no key_valid within 400 cycles, expected a pulse", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pressed = 16'h0000;
    exp_q.delete();
    model_num = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_release(input int k, input int hold);
    pressed[k] = 1'b1;
    exp_q.push_back(4'(k));
    repeat (hold) @(posedge clk);
    pressed = 16'h0000;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    logic [15:0] num_before;
    int          pulses_before;
    int          n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_col", col, 4'b1110);
    check("reset_num", num, 16'h0000);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_key_held", key_held, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single stable press of code 6, then release debounce
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid("wait_key6");
    check("key6_held", key_held, 1'b1);
    check("key6_num", num, 16'h0006);
    wait_tick();
    pressed = 16'h0000;
    wait_tick();
    wait_tick();
    check("key6_held_during_release", key_held, 1'b1);
    wait_tick();
    check("key6_released", key_held, 1'b0);
    repeat (20) @(posedge clk);

    // Five digits; the first one wraps out of the register
    do_reset();
    for (int k = 1; k <= 5; k++) press_release(k, 32);
    check("seq_num", num, 16'h2345);

    // Asynchronous reset in the middle of an in-flight press
    pressed[9] = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_col", col, 4'b1110);
    check("midrst_num", num, 16'h0000);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_key_held", key_held, 1'b0);
    do_reset();

    // Two-tick glitch in column 1 must be rejected
    n = 0;
    wait_tick();
    while (col != 4'b1101 && n < 8) begin
      wait_tick();
      n++;
    end
    check("glitch_col_found", col, 4'b1101);
    num_before = num;
    pulses_before = pulses;
    pressed[13] = 1'b1;
    wait_tick();
    wait_tick();
    pressed = 16'h0000;
    wait_tick();
    check("glitch_col_adv1", col, 4'b1011);
    wait_tick();
    check("glitch_col_adv2", col, 4'b0111);
    repeat (20) @(posedge clk);
    check("glitch_no_pulse", pulses, pulses_before);
    check("glitch_num", num, num_before);

    // Rows 0 and 2 low in column 1: lowest row wins -> code 1
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    exp_q.push_back(4'h1);
    repeat (32) @(posedge clk);
    pressed = 16'h0000;
    repeat (40) @(posedge clk);

    // Randomized single-key presses
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      press_release(int'($urandom_range(0, 15)), int'($urandom_range(30, 34)));
    end

    // Long hold of key A: auto-repeat only when the feature is built in
    do_reset();
    pressed[10] = 1'b1;
    exp_q.push_back(4'hA);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(4'hA);
    exp_q.push_back(4'hA);
`endif
    wait_valid("wait_keyA");
    repeat (20) wait_tick();
    pressed = 16'h0000;
    repeat (40) @(posedge clk);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_num", num, 16'h0AAA);
`else
    check("repeat_num", num, 16'h000A);
`endif

    check("all_pulses_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
